// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes, width helpers and types shared by the register file
package regfile_pkg;
  localparam int XLEN_D = 32;
  localparam int NREGS_D = 32;
  localparam int NRD_D = 2;
  function automatic int addr_w(input int nregs);
    return $clog2(nregs);
  endfunction
  function automatic int data_w(input int xlen);
    return xlen;
  endfunction
  function automatic int cnt_w(input int nregs);
    return $clog2(nregs + 1);
  endfunction
  typedef logic [addr_w(NREGS_D)-1:0] addr_t;
  typedef logic [data_w(XLEN_D)-1:0] data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bits, allocation handshake and pending count for in-flight destinations
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_D,
  parameter int ZERO_REG = 1,
  parameter int AW = addr_w(NREGS),
  parameter int PW = cnt_w(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    rd,
  input  logic             alloc_valid,
  input  logic [AW-1:0]    alloc_rd,
  input  logic             flush,
  output logic             alloc_ready,
  output logic [NREGS-1:0] busy,
  output logic [PW-1:0]    pending
);
  logic wr_hit, al_hit, inc, dec;
  logic [NREGS-1:0] busy_n;
  assign wr_hit = we && !(ZERO_REG != 0 && rd == '0);
  assign alloc_ready = !busy[alloc_rd] || (we && rd == alloc_rd);
  assign al_hit = alloc_valid && alloc_ready && !(ZERO_REG != 0 && alloc_rd == '0);
  assign inc = al_hit && !busy[alloc_rd];
  assign dec = wr_hit && busy[rd] && !(al_hit && alloc_rd == rd);
  // writeback clears first so a same-register allocation leaves the bit set
  always_comb begin
    busy_n = busy;
    if (wr_hit) busy_n[rd] = 1'b0;
    if (al_hit) busy_n[alloc_rd] = 1'b1;
  end
  // flush squashes every busy update; pending tracks the popcount incrementally
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      busy <= '0;
      pending <= '0;
    end else begin
      busy <= busy_n;
      pending <= pending + PW'(inc) - PW'(dec);
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write bypass, hardwired zero and busy scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREGS = NREGS_D,
  parameter int NRD = NRD_D,
  parameter int ZERO_REG = 1,
  localparam int AW = addr_w(NREGS),
  localparam int PW = cnt_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rs,
  output logic [NRD*XLEN-1:0] rv,
  output logic [NRD-1:0]      rs_busy,
  input  logic                we,
  input  logic [AW-1:0]       rd,
  input  logic [XLEN-1:0]     wdata,
  input  logic                alloc_valid,
  input  logic [AW-1:0]       alloc_rd,
  output logic                alloc_ready,
  input  logic                flush,
  output logic [PW-1:0]       pending
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic wr_hit;
  assign wr_hit = we && !(ZERO_REG != 0 && rd == '0);
  regfile_scoreboard #(.NREGS(NREGS), .ZERO_REG(ZERO_REG), .AW(AW), .PW(PW)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .rd(rd),
    .alloc_valid(alloc_valid),
    .alloc_rd(alloc_rd),
    .flush(flush),
    .alloc_ready(alloc_ready),
    .busy(busy),
    .pending(pending)
  );
  // data storage; flush does not block the writeback commit
  always_ff @(posedge clk) begin
    if (!rst_n) regs <= '{default: '0};
    else if (wr_hit) regs[rd] <= wdata;
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic z, b;
    assign a = rs[i*AW +: AW];
    assign z = ZERO_REG != 0 && a == '0;
    assign b = wr_hit && rd == a;
    // hardwired zero first, then same-cycle writeback bypass, then storage
    always_comb begin
      rv[i*XLEN +: XLEN] = z ? '0 : b ? wdata : regs[a];
      rs_busy[i] = !z && !b && busy[a];
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and model-checked scenarios for regfile_sb
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] rs;
  logic [63:0] rv;
  logic [1:0] rs_busy;
  logic we;
  logic [4:0] rd;
  logic [31:0] wdata;
  logic alloc_valid;
  logic [4:0] alloc_rd;
  logic alloc_ready;
  logic flush;
  logic [5:0] pending;
  int checks = 0;
  int failures = 0;
  logic [31:0] mbusy;
  logic [31:0] mregs [32];

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rv(rv), .rs_busy(rs_busy),
    .we(we), .rd(rd), .wdata(wdata), .alloc_valid(alloc_valid),
    .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .flush(flush), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; rd = '0; wdata = '0; alloc_valid = 1'b0; alloc_rd = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rs = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (pending !== 6'd0) begin failures++; $display("FAIL reset_pending got %0d exp 0", pending); end
    for (int r = 0; r < 32; r++) begin
      rs = {r[4:0], r[4:0]};
      #1;
      checks++;
      if (rv !== 64'd0 || rs_busy !== 2'b00) begin
        failures++; $display("FAIL reset_read r%0d got rv=%h busy=%b exp 0/00", r, rv, rs_busy);
      end
    end
  endtask

  task automatic test_bypass();
    idle();
    we = 1'b1; rd = 5'd5; wdata = 32'hDEADBEEF; rs = {5'd1, 5'd5};
    #1;
    checks++;
    if (rv[31:0] !== 32'hDEADBEEF || rs_busy[0] !== 1'b0) begin
      failures++; $display("FAIL bypass got %h busy=%b exp deadbeef 0", rv[31:0], rs_busy[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rv[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL storage_read got %h exp deadbeef", rv[31:0]); end
  endtask

  task automatic test_zero_reg();
    idle();
    we = 1'b1; rd = 5'd0; wdata = 32'h1234; rs = {5'd0, 5'd0};
    #1;
    checks++;
    if (rv !== 64'd0) begin failures++; $display("FAIL zero_bypass got %h exp 0", rv); end
    tick();
    idle();
    alloc_valid = 1'b1; alloc_rd = 5'd0;
    #1;
    checks++;
    if (rv !== 64'd0) begin failures++; $display("FAIL zero_store got %h exp 0", rv); end
    checks++;
    if (alloc_ready !== 1'b1) begin failures++; $display("FAIL zero_alloc_ready got %b exp 1", alloc_ready); end
    tick();
    idle();
    #1;
    checks++;
    if (pending !== 6'd0 || rs_busy !== 2'b00) begin
      failures++; $display("FAIL zero_alloc got pending=%0d busy=%b exp 0/00", pending, rs_busy);
    end
  endtask

  task automatic test_alloc_conflict();
    idle();
    alloc_valid = 1'b1; alloc_rd = 5'd7; rs = {5'd7, 5'd0};
    #1;
    checks++;
    if (alloc_ready !== 1'b1 || rs_busy[1] !== 1'b0) begin
      failures++; $display("FAIL alloc7_first got ready=%b busy=%b exp 1 0", alloc_ready, rs_busy[1]);
    end
    tick();
    checks++;
    if (alloc_ready !== 1'b0 || rs_busy[1] !== 1'b1 || pending !== 6'd1) begin
      failures++; $display("FAIL alloc7_again got ready=%b busy=%b pending=%0d exp 0 1 1", alloc_ready, rs_busy[1], pending);
    end
    we = 1'b1; rd = 5'd7; wdata = 32'h77;
    #1;
    checks++;
    if (alloc_ready !== 1'b1 || rs_busy[1] !== 1'b0 || rv[63:32] !== 32'h77) begin
      failures++; $display("FAIL alloc7_wb got ready=%b busy=%b rv=%h exp 1 0 77", alloc_ready, rs_busy[1], rv[63:32]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rs_busy[1] !== 1'b1 || pending !== 6'd1 || rv[63:32] !== 32'h77) begin
      failures++; $display("FAIL alloc7_net got busy=%b pending=%0d rv=%h exp 1 1 77", rs_busy[1], pending, rv[63:32]);
    end
    we = 1'b1; rd = 5'd7; wdata = 32'h78;
    tick();
    idle();
    #1;
    checks++;
    if (rs_busy[1] !== 1'b0 || pending !== 6'd0) begin
      failures++; $display("FAIL alloc7_retire got busy=%b pending=%0d exp 0 0", rs_busy[1], pending);
    end
  endtask

  task automatic test_flush();
    idle();
    alloc_valid = 1'b1;
    alloc_rd = 5'd3; tick();
    alloc_rd = 5'd4; tick();
    alloc_rd = 5'd9; tick();
    idle();
    rs = {5'd4, 5'd3};
    #1;
    checks++;
    if (pending !== 6'd3 || rs_busy !== 2'b11) begin
      failures++; $display("FAIL flush_pre got pending=%0d busy=%b exp 3 11", pending, rs_busy);
    end
    flush = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd10;
    tick();
    idle();
    #1;
    checks++;
    if (pending !== 6'd0 || rs_busy !== 2'b00) begin
      failures++; $display("FAIL flush_post got pending=%0d busy=%b exp 0 00", pending, rs_busy);
    end
    rs = {5'd10, 5'd9};
    #1;
    checks++;
    if (rs_busy !== 2'b00) begin failures++; $display("FAIL flush_alloc10 got busy=%b exp 00", rs_busy); end
  endtask

  task automatic test_reset_mid();
    idle();
    we = 1'b1; rd = 5'd2; wdata = 32'hAAAA;
    tick();
    idle();
    rs = {5'd5, 5'd2};
    #1;
    checks++;
    if (rv !== {32'hDEADBEEF, 32'hAAAA}) begin failures++; $display("FAIL pre_reset got %h exp deadbeef0000aaaa", rv); end
    rst_n = 1'b0; we = 1'b1; rd = 5'd2; wdata = 32'h5555; alloc_valid = 1'b1; alloc_rd = 5'd6;
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    checks++;
    if (rv !== 64'd0 || pending !== 6'd0) begin
      failures++; $display("FAIL mid_reset got rv=%h pending=%0d exp 0 0", rv, pending);
    end
  endtask

  task automatic test_random();
    logic exp_ready;
    logic [4:0] a0, a1;
    logic [1:0] exp_busy;
    logic [63:0] exp_rv;
    mbusy = '0;
    for (int r = 0; r < 32; r++) mregs[r] = '0;
    for (int c = 0; c < 300; c++) begin
      we = $urandom_range(0, 1) == 1;
      rd = 5'($urandom_range(0, 15));
      wdata = $urandom;
      alloc_valid = $urandom_range(0, 2) != 0;
      alloc_rd = 5'($urandom_range(0, 15));
      flush = $urandom_range(0, 15) == 0;
      a0 = 5'($urandom_range(0, 15));
      a1 = 5'($urandom_range(0, 15));
      rs = {a1, a0};
      exp_ready = !mbusy[alloc_rd] || (we && rd == alloc_rd);
      exp_busy[0] = a0 != 0 && !(we && rd == a0) && mbusy[a0];
      exp_busy[1] = a1 != 0 && !(we && rd == a1) && mbusy[a1];
      exp_rv[31:0] = a0 == 0 ? 32'd0 : (we && rd == a0) ? wdata : mregs[a0];
      exp_rv[63:32] = a1 == 0 ? 32'd0 : (we && rd == a1) ? wdata : mregs[a1];
      #1;
      checks++;
      if (alloc_ready !== exp_ready || rs_busy !== exp_busy || rv !== exp_rv) begin
        failures++;
        $display("FAIL rand_comb c%0d got ready=%b busy=%b rv=%h exp %b %b %h", c, alloc_ready, rs_busy, rv, exp_ready, exp_busy, exp_rv);
      end
      if (we && rd != 0) mregs[rd] = wdata;
      if (flush) mbusy = '0;
      else begin
        if (we && rd != 0) mbusy[rd] = 1'b0;
        if (alloc_valid && exp_ready && alloc_rd != 0) mbusy[alloc_rd] = 1'b1;
      end
      tick();
      checks++;
      if (pending !== 6'($countones(mbusy))) begin
        failures++; $display("FAIL rand_pending c%0d got %0d exp %0d", c, pending, $countones(mbusy));
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    rs = '0;
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_alloc_conflict();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with multiple combinational read ports, write-to-read bypass, hardwired-zero register and an integrated busy-bit scoreboard tracking in-flight destination registers. Sits between decode/issue and writeback: issue allocates a destination with `alloc_*`, writeback retires it with `we`/`rd`/`wdata`, and each read port reports both the operand value and whether it is still pending. Successor to the fixed 32x32, 2-read-port, unreset register file.

## Interface
- `XLEN`, 32, data width in bits
- `NREGS`, 32, number of architectural registers (power of two, >= 2)
- `NRD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, 1: register 0 reads 0, ignores writes, is never busy
- `AW`, derived, $clog2(NREGS); not user-set

- `clk`  in  1  clock; all state changes on posedge
- `rst_n`  in  1  reset, synchronous, active-low
- `rs`  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- `rv`  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- `rs_busy`  out  NRD  port i operand pending (not yet written back)
- `we`  in  1  writeback enable
- `rd`  in  AW  writeback address
- `wdata`  in  XLEN  writeback data
- `alloc_valid`  in  1  issue requests destination `alloc_rd`
- `alloc_rd`  in  AW  destination to mark busy
- `alloc_ready`  out  1  allocation accepted this cycle
- `flush`  in  1  clear all busy bits (pipeline squash)
- `pending`  out  $clog2(NREGS+1)  number of busy registers

## Operation
- Storage: NREGS x XLEN flops, busy[NREGS-1:0], pending counter.
- Read (combinational, per port): if `we` && `rd`==`rs[i]` && !(ZERO_REG && rd==0) then `rv[i]`=`wdata`, `rs_busy[i]`=0 (bypass); else `rv[i]`=reg[`rs[i]`], `rs_busy[i]`=busy[`rs[i]`]. ZERO_REG && `rs[i]`==0 -> `rv[i]`=0, `rs_busy[i]`=0.
- Write: posedge with `we` -> reg[`rd`]<=`wdata`, busy[`rd`]<=0. Write to non-busy register is legal (data committed, busy stays 0). ZERO_REG && `rd`==0 -> no effect.
- `alloc_ready` = !busy[`alloc_rd`] || (`we` && `rd`==`alloc_rd`); combinational, independent of `alloc_valid`. Always 1 for `alloc_rd`==0 with ZERO_REG.
- Allocate: posedge with `alloc_valid` && `alloc_ready` -> busy[`alloc_rd`]<=1 (not for reg 0 with ZERO_REG).
- Same register written back and allocated in one cycle: net busy=1 (alloc wins over clear).
- `flush`: busy<=0 and `pending`<=0 next edge; overrides same-cycle alloc and writeback busy updates; writeback data still committed.
- `pending` = popcount(busy) maintained incrementally: +1 on accepted alloc of non-busy reg, -1 on writeback of busy reg, net 0 when both hit the same reg or alloc and writeback retire/allocate different regs together. Must always equal popcount(busy).

## Timing
- Reset: `rst_n`==0 at posedge -> all registers 0, busy 0, `pending` 0; writes/allocs on that edge dropped. Outputs during reset are combinational from state (rv reflects pre-reset contents until the edge, bypass still active).
- Read latency 0 (combinational); write-to-read through storage 1 cycle, through bypass 0 cycles.
- Allocation effective on `rs_busy` from the cycle after acceptance.
- No internal multi-cycle states; every request completes at the edge it is presented.

## Structure
- `regfile_pkg`: default XLEN/NREGS/NRD constants, `addr_t`/`data_t` parametric width helpers, popcount-width function.
- Sub-module `regfile_scoreboard`: busy vector, alloc_ready, flush, `pending` counter; top holds data array, read muxes and bypass.

## Test plan
- Reset then read all registers via both ports -> all `rv`=0, `rs_busy`=0, `pending`=0.
- `we`=1, `rd`=5, `wdata`=0xDEADBEEF with `rs[0]`=5 same cycle -> `rv[0]`=0xDEADBEEF combinationally; next cycle via storage same value.
- Write 0x1234 to reg 0 (ZERO_REG=1) -> `rv` for reg 0 stays 0; alloc reg 0 -> `pending` stays 0.
- Alloc reg 7; next cycle alloc reg 7 again -> `alloc_ready`=0; same cycle `we`,`rd`=7 -> `alloc_ready`=1, busy[7] stays 1, `pending`=1.
- Alloc regs 3,4,9 over 3 cycles (`pending`=3), then `flush` with simultaneous alloc reg 10 -> `pending`=0, all `rs_busy`=0.
- `rst_n`=0 for one edge mid-stream with `we`,`rd`=2 -> reg 2 reads 0 after reset; random alloc/writeback/flush run with `pending`==popcount(busy) checked every cycle.
